mac_acumulador: RTL and testbench

//  Control and register stage of the filter multiply-accumulate loop; sits directly downstream of Mux_Ac.
//  Per input sample it drives Mux_Ac's select, registers the mux output Y plus the multiplier product into
//  the accumulator, and feeds the accumulator back to Mux_Ac's Acum input.
//  It sequences TAPS products, saturates to N-bit signed two's complement, and presents the result with a 1-cycle done strobe.

---
 rtl/mac_acumulador_pkg.sv | 18 +
 rtl/mac_acumulador_if.sv | 30 +++
 rtl/mac_acumulador_sumador_sat.sv | 27 ++
 rtl/mac_acumulador.sv | 107 ++++++++++
 tb/tb_mac_acumulador.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mac_acumulador_pkg.sv
// Shared select codes, FSM state encoding and default data width for the
// filter multiply-accumulate control block.
package mac_acumulador_pkg;

  localparam int N_DEFAULT = 25;

  localparam logic [1:0] SEL_UK   = 2'b00;
  localparam logic [1:0] SEL_ACUM = 2'b01;
  localparam logic [1:0] SEL_CERO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_ACC  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_acumulador_if.sv
// Bundle between the MAC control block and its neighbours (Mux_Ac, multiplier,
// sample requester). The master side drives requests and datapath inputs.
interface mac_acumulador_if
  import mac_acumulador_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int TW = 8
);
  logic                 start;
  logic                 use_uk;
  logic signed [N-1:0]  mux_y;
  logic signed [N-1:0]  prod;
  logic [1:0]           select;
  logic signed [N-1:0]  acum;
  logic [TW-1:0]        tap_idx;
  logic signed [N-1:0]  y_out;
  logic                 done;
  logic                 busy;
  logic                 ovf;

  modport master (
    output start, use_uk, mux_y, prod,
    input  select, acum, tap_idx, y_out, done, busy, ovf
  );

  modport slave (
    input  start, use_uk, mux_y, prod,
    output select, acum, tap_idx, y_out, done, busy, ovf
  );
endinterface

// File: rtl/mac_acumulador_sumador_sat.sv
// Combinational saturating adder: N-bit signed operands, sum formed at N+1 bits
// and clamped back to the N-bit signed range.
module mac_acumulador_sumador_sat #(
  parameter int N = 25
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] sum,
  output logic                ovf
);

  // The two top bits of the wide sum disagree exactly when N bits cannot hold it.
  function automatic logic signed [N-1:0] sat(input logic signed [N:0] s);
    if (s[N] == s[N-1]) return s[N-1:0];
    else if (s[N])      return {1'b1, {(N-1){1'b0}}};
    else                return {1'b0, {(N-1){1'b1}}};
  endfunction

  logic signed [N:0] wide;

  always_comb begin
    wide = (N+1)'(a) + (N+1)'(b);
    sum  = sat(wide);
    ovf  = wide[N] ^ wide[N-1];
  end

endmodule

// File: rtl/mac_acumulador.sv
// Sequencer and accumulator register for the filter MAC loop: seeds from Mux_Ac,
// accumulates TAPS saturated products, then publishes the sample with a done strobe.
module mac_acumulador
  import mac_acumulador_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int TAPS = 3,
  parameter int TW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  mac_acumulador_if.slave   bus
);

  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

  state_t              state_q, state_d;
  logic signed [N-1:0] acum_q, acum_d;
  logic signed [N-1:0] y_out_q, y_out_d;
  logic [TW-1:0]       tap_idx_q, tap_idx_d;
  logic                uk_sel_q, uk_sel_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic signed [N-1:0] sum;
  logic                sum_ovf;

  mac_acumulador_sumador_sat #(.N(N)) u_sumador (
    .a   (bus.mux_y),
    .b   (bus.prod),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acum_d    = acum_q;
    y_out_d   = y_out_q;
    tap_idx_d = tap_idx_q;
    uk_sel_d  = uk_sel_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d   = ST_SEED;
        uk_sel_d  = bus.use_uk;
        ovf_d     = 1'b0;
        tap_idx_d = '0;
      end
      ST_SEED: begin
        acum_d  = bus.mux_y;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acum_d    = sum;
        ovf_d     = ovf_q | sum_ovf;
        tap_idx_d = tap_idx_q + TW'(1);
        // Result and strobe are loaded on the way into OUT so both are visible during OUT.
        if (tap_idx_q == LAST_TAP) begin
          state_d = ST_OUT;
          y_out_d = sum;
          done_d  = 1'b1;
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      acum_q    <= '0;
      y_out_q   <= '0;
      tap_idx_q <= '0;
      uk_sel_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acum_q    <= acum_d;
      y_out_q   <= y_out_d;
      tap_idx_q <= tap_idx_d;
      uk_sel_q  <= uk_sel_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Select 11 (Mux_Ac default) is never produced.
  always_comb begin
    bus.select = SEL_ACUM;
    if (state_q == ST_SEED) bus.select = uk_sel_q ? SEL_UK : SEL_CERO;
  end

  assign bus.acum    = acum_q;
  assign bus.y_out   = y_out_q;
  assign bus.tap_idx = tap_idx_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mac_acumulador.sv
// Directed bench: behavioural Mux_Ac model around two mac_acumulador builds
// (TAPS=3 and TAPS=1), checked against hand-computed results.
module tb_mac_acumulador;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_acumulador_if #(.N(25), .TW(8)) a_if ();
  mac_acumulador_if #(.N(25), .TW(8)) b_if ();

  mac_acumulador #(.N(25), .TAPS(3), .TW(8)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  mac_acumulador #(.N(25), .TAPS(1), .TW(8)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  logic signed [24:0] uk_a;
  logic signed [24:0] prod_tab [4];
  logic [1:0]         sel_log [21];
  int n_tests = 0;
  int n_fail  = 0;

  // Mux_Ac model: 00 Uk, 01 Acum, 10 zero.
  always_comb begin
    case (a_if.select)
      2'b00:   a_if.mux_y = uk_a;
      2'b01:   a_if.mux_y = a_if.acum;
      default: a_if.mux_y = '0;
    endcase
    case (b_if.select)
      2'b01:   b_if.mux_y = b_if.acum;
      default: b_if.mux_y = '0;
    endcase
    a_if.prod = prod_tab[a_if.tap_idx[1:0]];
    b_if.prod = 25'sd7;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_prods(input logic signed [24:0] p0, p1, p2);
    prod_tab[0] = p0; prod_tab[1] = p1; prod_tab[2] = p2; prod_tab[3] = '0;
  endtask

  task automatic run_a(input logic uk_sel, input logic [24:0] uk, output int done_cyc,
                       output logic ovf_seed);
    @(negedge clk);
    uk_a = uk; a_if.use_uk = uk_sel; a_if.start = 1'b1;
    @(posedge clk);
    #1 a_if.start = 1'b0; a_if.use_uk = 1'b0;
    done_cyc = -1; ovf_seed = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sel_log[c] = a_if.select;
      if (c == 1) ovf_seed = a_if.ovf;
      if (a_if.done) begin done_cyc = c; break; end
    end
  endtask

  initial begin
    int dc;
    logic os;
    int n_done, n_acc;
    int tap_seq [4];
    a_if.start = 1'b0; a_if.use_uk = 1'b0;
    b_if.start = 1'b0; b_if.use_uk = 1'b0;
    uk_a = '0;
    set_prods(25'sd0, 25'sd0, 25'sd0);

    // Reset state
    @(posedge clk); #1;
    check("rst_acum", $unsigned(a_if.acum), 0);
    check("rst_y", $unsigned(a_if.y_out), 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_sel", a_if.select, 2'b01);
    @(negedge clk); reset = 1'b1;

    // Seed from Uk, small products
    set_prods(25'sh10, 25'sh20, 25'sh30);
    run_a(1'b1, 25'h000100, dc, os);
    check("t2_done_cyc", dc, 5);
    check("t2_y", $unsigned(a_if.y_out), 25'h000160);
    check("t2_ovf", a_if.ovf, 0);
    check("t2_sel_seed", sel_log[1], 2'b00);
    @(negedge clk);
    check("t2_done_1cyc", a_if.done, 0);
    check("t2_idle_busy", a_if.busy, 0);

    // Zero seed, negative products
    set_prods(-25'sd5, -25'sd5, -25'sd5);
    run_a(1'b0, 25'h0, dc, os);
    check("t3_done_cyc", dc, 5);
    check("t3_sel1", sel_log[1], 2'b10);
    check("t3_sel2", sel_log[2], 2'b01);
    check("t3_sel3", sel_log[3], 2'b01);
    check("t3_sel4", sel_log[4], 2'b01);
    check("t3_y", $unsigned(a_if.y_out), 25'h1FFFFF1);
    check("t3_ovf", a_if.ovf, 0);

    // Positive saturation
    set_prods(25'sh20, 25'sh20, 25'sh20);
    run_a(1'b1, 25'h0FFFFF0, dc, os);
    check("t4_y", $unsigned(a_if.y_out), 25'h0FFFFFF);
    check("t4_ovf", a_if.ovf, 1);

    // Negative saturation; the accepted start clears the old ovf
    set_prods(-25'sh20, -25'sh20, -25'sh20);
    run_a(1'b1, 25'h1000010, dc, os);
    check("t4_ovf_cleared", os, 0);
    check("neg_y", $unsigned(a_if.y_out), 25'h1000000);
    check("neg_ovf", a_if.ovf, 1);

    // start held high through the run (including OUT) is not queued
    set_prods(25'sd1, 25'sd2, 25'sd3);
    @(negedge clk);
    a_if.use_uk = 1'b0; a_if.start = 1'b1;
    @(posedge clk);
    n_done = 0; n_acc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 6) a_if.start = 1'b0;
      if (a_if.done) n_done++;
      if (a_if.busy && a_if.select == 2'b01 && !a_if.done) begin
        if (n_acc < 4) tap_seq[n_acc] = int'(a_if.tap_idx);
        n_acc++;
      end
    end
    check("t5_dones", n_done, 1);
    check("t5_acc_cycles", n_acc, 3);
    check("t5_tap0", tap_seq[0], 0);
    check("t5_tap1", tap_seq[1], 1);
    check("t5_tap2", tap_seq[2], 2);
    check("t5_y", $unsigned(a_if.y_out), 25'd6);
    check("t5_busy_end", a_if.busy, 0);

    // Asynchronous reset in the middle of ACC aborts the sample
    @(negedge clk);
    a_if.use_uk = 1'b0; a_if.start = 1'b1;
    @(posedge clk);
    #1 a_if.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t1_acum", $unsigned(a_if.acum), 0);
    check("t1_y", $unsigned(a_if.y_out), 0);
    check("t1_tap", a_if.tap_idx, 0);
    check("t1_busy", a_if.busy, 0);
    check("t1_done", a_if.done, 0);
    check("t1_sel", a_if.select, 2'b01);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_if.done) n_done++;
    end
    check("t1_no_done", n_done, 0);
    check("t1_y_after", $unsigned(a_if.y_out), 0);

    // TAPS=1 build
    @(negedge clk);
    b_if.use_uk = 1'b0; b_if.start = 1'b1;
    @(posedge clk);
    #1 b_if.start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (b_if.done) begin dc = c; break; end
    end
    check("t6_done_cyc", dc, 3);
    check("t6_y", $unsigned(b_if.y_out), 25'd7);
    check("t6_ovf", b_if.ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
